// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and flag helper for the sequential ALU
// Contents: aluk_t op codes, state_t FSM states, nzp_of() flag encoder.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_AND  = 3'b001,
    ALU_NOT  = 3'b010,
    ALU_PASS = 3'b011,
    ALU_SHL  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_SRA  = 3'b110,
    ALU_MUL  = 3'b111
  } aluk_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // {N,Z,P}: exactly one bit set; zero takes priority over the sign bit.
  function automatic logic [2:0] nzp_of(input logic neg, input logic zero);
    return zero ? 3'b010 : (neg ? 3'b100 : 3'b001);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - iterative shifter and optional shift-add multiplier
// Ports: Clk, Reset (sync, active-high), start/op/a/b load a new job;
//        done is high in the cycle whose update finishes the job, and
//        value/carry then present the finished (next-state) result.
// Build option: ALU_SEQ_MUL_EN adds the WIDTH-cycle multiplier for ALU_MUL.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  aluk_t            op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  logic [SHW:0]     cnt_q;
  logic [SHW:0]     cnt_load;
  aluk_t            op_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_next;

  always_comb begin
    sh_next = sh_q;
    case (op_q)
      ALU_SHL: sh_next = sh_q << 1;
      ALU_SRL: sh_next = sh_q >> 1;
      default: sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    endcase
  end

  // The job ends on the update that takes the counter from 1 to 0, so the
  // caller can capture value on that same edge.
  assign done = (cnt_q == CNT_ONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
      op_q  <= ALU_ADD;
      sh_q  <= '0;
    end else if (start) begin
      cnt_q <= cnt_load;
      op_q  <= op;
      sh_q  <= a;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_ONE;
      sh_q  <= sh_next;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_q;

  assign cnt_load = (op == ALU_MUL) ? (SHW+1)'(WIDTH) : {1'b0, b[SHW-1:0]};
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (cnt_q != '0) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign value = (op_q == ALU_MUL) ? acc_next[WIDTH-1:0] : sh_next;
  assign carry = (op_q == ALU_MUL) && (|acc_next[2*WIDTH-1:WIDTH]);
`else
  logic unused_b;

  assign cnt_load = {1'b0, b[SHW-1:0]};
  assign unused_b = ^b[WIDTH-1:SHW];
  assign value    = sh_next;
  assign carry    = 1'b0;
`endif

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with registered result and flags
// Ports: Clk, Reset (sync, active-high); in_valid/in_ready op request;
//        sr1 (A), sr2/imm selected by sr2mux (B), aluk op code;
//        out_valid/out_ready result handshake; result, nzp {N,Z,P}, co.
// Build option: ALU_SEQ_MUL_EN makes aluk=111 an iterative multiply,
//        otherwise it behaves as PASS.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sr1,
  input  logic [WIDTH-1:0] sr2,
  input  logic [WIDTH-1:0] imm,
  input  logic             sr2mux,
  input  logic [2:0]       aluk,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp,
  output logic             co
);

  state_t           state;
  aluk_t            op;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] quick_res;
  logic             quick_co;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             is_mul;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_value;
  logic             iter_carry;

  assign op       = aluk_t'(aluk);
  assign b_sel    = sr2mux ? imm : sr2;
  assign shamt    = b_sel[SHW-1:0];
  assign is_shift = op inside {ALU_SHL, ALU_SRL, ALU_SRA};

`ifdef ALU_SEQ_MUL_EN
  assign is_mul = (op == ALU_MUL);
`else
  assign is_mul = 1'b0;
`endif

  // Shift-by-0 never enters BUSY; it completes like a single-cycle op.
  assign iter_start = (state == IDLE) && in_valid &&
                      ((is_shift && (shamt != '0)) || is_mul);

  // Single-cycle ops; PASS, shift-by-0 and a disabled MUL all yield A.
  always_comb begin
    quick_res = sr1;
    quick_co  = 1'b0;
    case (op)
      ALU_ADD: {quick_co, quick_res} = {1'b0, sr1} + {1'b0, b_sel};
      ALU_AND: quick_res = sr1 & b_sel;
      ALU_NOT: quick_res = ~sr1;
      default: ;
    endcase
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .Clk   (Clk),
    .Reset (Reset),
    .start (iter_start),
    .op    (op),
    .a     (sr1),
    .b     (b_sel),
    .done  (iter_done),
    .value (iter_value),
    .carry (iter_carry)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      nzp       <= 3'b010;
      co        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (iter_start) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= quick_res;
              co        <= quick_co;
              nzp       <= nzp_of(quick_res[WIDTH-1], quick_res == '0);
            end
          end
        end
        BUSY: begin
          if (iter_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= iter_value;
            co        <= iter_carry;
            nzp       <= nzp_of(iter_value[WIDTH-1], iter_value == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=16)
module tb_alu_seq;

  localparam int W  = 16;
  localparam int SH = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] sr1 = '0;
  logic [W-1:0] sr2 = '0;
  logic [W-1:0] imm = '0;
  logic         sr2mux = 1'b0;
  logic [2:0]   aluk = 3'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [2:0]   nzp;
  logic         co;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sr1       (sr1),
    .sr2       (sr2),
    .imm       (imm),
    .sr2mux    (sr2mux),
    .aluk      (aluk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .nzp       (nzp),
    .co        (co)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference model: plain arithmetic on the op definition.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic cout, output int lat);
    int k;
    logic [W:0] sum;
    k    = int'(b[SH-1:0]);
    res  = a;
    cout = 1'b0;
    lat  = 1;
    case (op)
      3'd0: begin sum = {1'b0, a} + {1'b0, b}; res = sum[W-1:0]; cout = sum[W]; end
      3'd1: res = a & b;
      3'd2: res = ~a;
      3'd4: begin res = a << k; lat = k + 1; end
      3'd5: begin res = a >> k; lat = k + 1; end
      3'd6: begin res = W'($signed(a) >>> k); lat = k + 1; end
      3'd7: begin
`ifdef ALU_SEQ_MUL_EN
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        res  = prod[W-1:0];
        cout = |prod[2*W-1:W];
        lat  = W + 1;
`endif
      end
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] flags_of(input logic [W-1:0] r);
    if (r == 0) return 3'b010;
    if (r[W-1]) return 3'b100;
    return 3'b001;
  endfunction

  // Offers one op, waits for acceptance, scrambles operands, counts cycles to out_valid.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] s2,
                       input logic [W-1:0] im, input logic mux,
                       output int lat, output logic busy_rdy, output int waited);
    waited = 0;
    @(negedge Clk);
    while (!in_ready && waited < 40) begin
      @(negedge Clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL issue_wait in_ready=%b required 1", in_ready);
    end
    aluk = op; sr1 = a; sr2 = s2; imm = im; sr2mux = mux; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    sr1 = W'($urandom); sr2 = W'($urandom); imm = W'($urandom);
    aluk = 3'($urandom); sr2mux = 1'($urandom);
    lat = 1;
    busy_rdy = 1'b0;
    while (!out_valid && lat < 64) begin
      if (in_ready) busy_rdy = 1'b1;
      @(posedge Clk); #1;
      lat++;
    end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL out_valid_timeout out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic consume;
    @(negedge Clk);
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, result, nzp, co} !== {1'b0, 1'b1, 16'h0000, 3'b010, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got ov=%b ir=%b res=%h nzp=%b co=%b required ov=0 ir=1 res=0000 nzp=010 co=0",
               out_valid, in_ready, result, nzp, co);
    end
    // Abort an SHL by 5 two cycles into the shift.
    @(negedge Clk);
    aluk = 3'd4; sr1 = 16'h00F0; sr2 = 16'h0005; sr2mux = 1'b0; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL shift_busy_ready got %b required 0", in_ready);
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, result, nzp, co} !== {1'b0, 1'b1, 16'h0000, 3'b010, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midshift got ov=%b ir=%b res=%h nzp=%b co=%b required ov=0 ir=1 res=0000 nzp=010 co=0",
               out_valid, in_ready, result, nzp, co);
    end
    repeat (10) @(posedge Clk);
    #1;
    n_checks++;
    if ({out_valid, result} !== {1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_abort got ov=%b res=%h required ov=0 res=0000", out_valid, result);
    end
  endtask

  task automatic test_add_carry;
    int lat, waited;
    logic br;
    issue(3'd0, 16'hFFFF, 16'h1234, 16'h0001, 1'b1, lat, br, waited);
    n_checks++;
    if ({lat, result, co, nzp} !== {32'd1, 16'h0000, 1'b1, 3'b010}) begin
      n_fail++;
      $display("FAIL add_carry got lat=%0d res=%h co=%b nzp=%b required lat=1 res=0000 co=1 nzp=010",
               lat, result, co, nzp);
    end
    consume();
  endtask

  task automatic test_sra;
    int lat, waited;
    logic br;
    issue(3'd6, 16'h8000, 16'h0004, 16'h0007, 1'b0, lat, br, waited);
    n_checks++;
    if ({lat, result, co, nzp} !== {32'd5, 16'hF800, 1'b0, 3'b100}) begin
      n_fail++;
      $display("FAIL sra got lat=%0d res=%h co=%b nzp=%b required lat=5 res=f800 co=0 nzp=100",
               lat, result, co, nzp);
    end
    n_checks++;
    if ({br, in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL sra_in_ready got seen_busy=%b done=%b required 0 0", br, in_ready);
    end
    consume();
  endtask

  task automatic test_shl_zero;
    int lat, waited;
    logic br;
    issue(3'd4, 16'h0003, 16'h0000, 16'h0009, 1'b0, lat, br, waited);
    n_checks++;
    if ({lat, result, co, nzp} !== {32'd1, 16'h0003, 1'b0, 3'b001}) begin
      n_fail++;
      $display("FAIL shl_zero got lat=%0d res=%h co=%b nzp=%b required lat=1 res=0003 co=0 nzp=001",
               lat, result, co, nzp);
    end
    consume();
  endtask

  task automatic test_done_hold;
    int lat, waited;
    logic br;
    issue(3'd0, 16'h1111, 16'h2222, 16'h0000, 1'b0, lat, br, waited);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      in_valid = (i == 3); aluk = 3'd2; sr1 = 16'h0F0F;
      @(posedge Clk); #1;
      n_checks++;
      if ({out_valid, in_ready, result, nzp} !== {1'b1, 1'b0, 16'h3333, 3'b001}) begin
        n_fail++;
        $display("FAIL done_hold[%0d] got ov=%b ir=%b res=%h nzp=%b required ov=1 ir=0 res=3333 nzp=001",
                 i, out_valid, in_ready, result, nzp);
      end
    end
    in_valid = 1'b0;
    consume();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL done_release got ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
    end
    issue(3'd1, 16'hF0F0, 16'h0000, 16'h3C3C, 1'b1, lat, br, waited);
    n_checks++;
    if ({waited, lat, result, nzp} !== {32'd0, 32'd1, 16'h3030, 3'b001}) begin
      n_fail++;
      $display("FAIL back_to_back got wait=%0d lat=%0d res=%h nzp=%b required wait=0 lat=1 res=3030 nzp=001",
               waited, lat, result, nzp);
    end
    consume();
  endtask

  task automatic test_mul;
    int lat, waited;
    logic br;
    int e_lat;
    logic e_co;
`ifdef ALU_SEQ_MUL_EN
    e_lat = 17; e_co = 1'b1;
`else
    e_lat = 1; e_co = 1'b0;
`endif
    issue(3'd7, 16'h0100, 16'h0101, 16'h0000, 1'b0, lat, br, waited);
    n_checks++;
    if ({lat, result, co, nzp} !== {e_lat, 16'h0100, e_co, 3'b001}) begin
      n_fail++;
      $display("FAIL mul got lat=%0d res=%h co=%b nzp=%b required lat=%0d res=0100 co=%b nzp=001",
               lat, result, co, nzp, e_lat, e_co);
    end
    consume();
  endtask

  task automatic test_random;
    int lat, waited, e_lat;
    logic br, e_co, mux;
    logic [2:0] op;
    logic [W-1:0] a, s2, im, e_res;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom); a = W'($urandom); s2 = W'($urandom); im = W'($urandom);
      mux = 1'($urandom);
      if (n % 8 == 0) a = '0;
      model(op, a, mux ? im : s2, e_res, e_co, e_lat);
      issue(op, a, s2, im, mux, lat, br, waited);
      n_checks++;
      if ({lat, result, co, nzp, br} !== {e_lat, e_res, e_co, flags_of(e_res), 1'b0}) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got lat=%0d res=%h co=%b nzp=%b rdy=%b required lat=%0d res=%h co=%b nzp=%b rdy=0",
                 n, op, a, mux ? im : s2, lat, result, co, nzp, br, e_lat, e_res, e_co, flags_of(e_res));
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sra();
    test_shl_zero();
    test_done_hold();
    test_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
